bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter DATA_W, default 8, width of the parallel input word (legal range 2..32).
REQ-002 Parameter GAP, default 0, number of idle cycles inserted after each word (legal range 0..15).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  DATA_W  parallel word to serialize.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 dout  output  1  serial bit stream to the downstream serial consumer, which samples every cycle.
REQ-009 dout_valid  output  1  dout carries a data or parity bit.
REQ-010 dout_last  output  1  dout carries the final bit of the current word.

Function
REQ-011 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is captured into an internal shift register at that edge.
REQ-012 The FSM SHALL use the states IDLE, SHIFT, PAR (present only with SER_PARITY_EN) and GAP.
REQ-013 IDLE: in_ready=1; on transfer -> SHIFT.
REQ-014 SHIFT: the block SHALL emit in_data MSB first, one bit per cycle, for DATA_W cycles, with dout_valid=1.
REQ-015 The first bit (in_data[DATA_W-1]) SHALL appear on dout in the cycle after the transfer edge, giving a latency of 1.
REQ-016 After the last SHIFT bit, the FSM SHALL go -> PAR if parity is enabled; otherwise -> GAP if GAP>0, else -> IDLE.
REQ-017 GAP: the FSM SHALL hold for exactly GAP cycles with dout=0, dout_valid=0 and in_ready=0, then -> IDLE.
REQ-018 When not emitting a bit (IDLE or GAP), dout, dout_valid and dout_last SHALL all be 0.
REQ-019 dout_last SHALL be 1 only during the final emitted bit of a word (the last data bit, or the parity bit when enabled).
REQ-020 Back-to-back: with GAP=0, in_ready SHALL also be 1 during the dout_last cycle.
REQ-021 A transfer during the dout_last cycle SHALL put the next word's MSB on dout in the following cycle, with no idle bit between words.
REQ-022 in_ready SHALL be 0 in every other non-IDLE cycle; in_valid/in_data SHALL be ignored when in_ready=0.
REQ-023 dout, dout_valid, dout_last and in_ready SHALL be registered outputs with no combinational path from the inputs.
REQ-024 A bit counter SHALL be ceil(log2(DATA_W+1)) bits wide and SHALL never wrap mid-word; the GAP counter SHALL be 4 bits wide.

Reset
REQ-025 While reset=1: FSM=IDLE, shift register=0, counters=0, dout=0, dout_valid=0, dout_last=0, in_ready=0.
REQ-026 Reset asserted mid-word SHALL abort the word immediately; the partial word is discarded and is never resumed.
REQ-027 in_ready SHALL rise on the first rising clk edge after reset deasserts.

Configuration
REQ-028 Macro SER_PARITY_EN: when defined, PAR SHALL emit one extra bit after the data bits equal to the XOR of the captured word (even parity), with dout_valid=1 and dout_last=1.
REQ-029 Without SER_PARITY_EN, the PAR state and parity logic SHALL be absent, and each word SHALL occupy exactly DATA_W valid cycles.

Verification
REQ-030 DATA_W=8, GAP=0, no parity: transfer 8'h99 -> dout 1,0,0,1,1,0,0,1 on the 8 cycles after the transfer edge, dout_last on the 8th, then dout=0.
REQ-031 GAP=0, in_valid held high with words 8'hA5 then 8'h3C -> 16 consecutive dout_valid cycles 10100101 00111100, dout_last on cycles 8 and 16.
REQ-032 GAP=3: two words offered continuously -> exactly 3 cycles of dout=0/dout_valid=0 between words, then 1 cycle of IDLE before the second MSB.
REQ-033 SER_PARITY_EN, word 8'h07 -> 9 valid bits 00000111 then 1, with dout_last on the parity bit; word 8'h03 -> parity bit 0.
REQ-034 reset pulsed during the 4th bit of 8'hFF -> dout=0 and in_ready=0 immediately; in_ready=1 one edge after release, and the next word 8'h81 is emitted intact.
REQ-035 in_valid toggled while in_ready=0 during SHIFT -> no capture; the current word's bit sequence is unchanged.

Source files
------------

// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first parallel-to-serial converter with a valid/ready
// input handshake and an optional idle gap after each word.
// Optional feature: define SER_PARITY_EN to append an even-parity bit
// (the XOR of the captured word) after the data bits of every word.
// All outputs are registered. The reset is asynchronous and active-high.
`timescale 1ns/1ps

module bit_serializer #(
    parameter int DATA_W = 8,   // parallel word width, 2..32
    parameter int GAP    = 0    // idle cycles after each word, 0..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              dout_last
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_PEN  = CNT_W'(DATA_W - 1);
    localparam logic [3:0]        GAP_LAST = 4'(GAP);

    // Each state names what dout shows during the current cycle.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef SER_PARITY_EN
        S_PAR   = 2'd2,
`endif
        S_GAP   = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;   // bits already placed on dout
    logic [3:0]          gap_cnt_reg, gap_cnt_next;   // gap cycles already spent
    logic                dout_reg, dout_next;
    logic                dout_valid_reg, dout_valid_next;
    logic                dout_last_reg, dout_last_next;
    logic                in_ready_reg, in_ready_next;
`ifdef SER_PARITY_EN
    logic                parity_reg, parity_next;
`endif

    // A word is accepted only while the registered ready is high.
    logic load;
    assign load = in_valid & in_ready_reg;

    assign in_ready   = in_ready_reg;
    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign dout_last  = dout_last_reg;

    // State register: FSM, datapath and registered outputs; reset aborts any word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            dout_reg       <= 1'b0;
            dout_valid_reg <= 1'b0;
            dout_last_reg  <= 1'b0;
            in_ready_reg   <= 1'b0;
`ifdef SER_PARITY_EN
            parity_reg     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            dout_last_reg  <= dout_last_next;
            in_ready_reg   <= in_ready_next;
`ifdef SER_PARITY_EN
            parity_reg     <= parity_next;
`endif
        end
    end

    // Next-state logic: capture on transfer, shift per bit, then parity/gap/idle.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
`ifdef SER_PARITY_EN
        parity_next  = parity_reg;
`endif
        if (load) begin
            // The captured MSB goes straight to dout, so one bit is already out.
            state_next   = S_SHIFT;
            shift_next   = in_data;
            bit_cnt_next = CNT_W'(1);
            gap_cnt_next = '0;
`ifdef SER_PARITY_EN
            parity_next  = ^in_data;
`endif
        end else begin
            case (state_reg)
                S_SHIFT: begin
                    if (bit_cnt_reg != CNT_LAST) begin
                        shift_next   = shift_reg << 1;
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end else begin
                        bit_cnt_next = '0;
`ifdef SER_PARITY_EN
                        state_next   = S_PAR;
`else
                        if (GAP > 0) begin
                            state_next   = S_GAP;
                            gap_cnt_next = 4'd1;
                        end else begin
                            state_next   = S_IDLE;
                        end
`endif
                    end
                end
`ifdef SER_PARITY_EN
                S_PAR: begin
                    if (GAP > 0) begin
                        state_next   = S_GAP;
                        gap_cnt_next = 4'd1;
                    end else begin
                        state_next   = S_IDLE;
                    end
                end
`endif
                S_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_next   = S_IDLE;
                        gap_cnt_next = '0;
                    end else begin
                        gap_cnt_next = gap_cnt_reg + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: values the outputs take in the next cycle.
    always_comb begin
        dout_next       = 1'b0;
        dout_valid_next = 1'b0;
        dout_last_next  = 1'b0;
        in_ready_next   = 1'b0;
        if (load) begin
            dout_next       = in_data[DATA_W-1];
            dout_valid_next = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: in_ready_next = 1'b1;
                S_SHIFT: begin
                    if (bit_cnt_reg != CNT_LAST) begin
                        dout_next       = shift_reg[DATA_W-2];
                        dout_valid_next = 1'b1;
`ifndef SER_PARITY_EN
                        // Final data bit closes the word; back-to-back needs ready here.
                        if (bit_cnt_reg == CNT_PEN) begin
                            dout_last_next = 1'b1;
                            in_ready_next  = (GAP == 0);
                        end
`endif
                    end else begin
`ifdef SER_PARITY_EN
                        dout_next       = parity_reg;
                        dout_valid_next = 1'b1;
                        dout_last_next  = 1'b1;
`endif
                        in_ready_next   = (GAP == 0);
                    end
                end
`ifdef SER_PARITY_EN
                S_PAR: in_ready_next = (GAP == 0);
`endif
                S_GAP: in_ready_next = (gap_cnt_reg == GAP_LAST);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed testbench for bit_serializer: table of words plus hand-written
// sequences for back-to-back, gap, input noise and mid-word reset.
// Two instances share the clock and reset: dut (GAP=0) and dut_g (GAP=3).
`timescale 1ns/1ps

module tb_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data, g_data;
    logic       in_valid, g_valid;
    logic       in_ready, dout, dout_valid, dout_last;
    logic       g_ready, g_dout, g_dout_valid, g_dout_last;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(8), .GAP(0)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last)
    );

    bit_serializer #(.DATA_W(8), .GAP(3)) dut_g (
        .clk(clk), .reset(reset), .in_data(g_data), .in_valid(g_valid),
        .in_ready(g_ready), .dout(g_dout), .dout_valid(g_dout_valid), .dout_last(g_dout_last)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] bits;   // expected serial order, first bit on the left
        logic       par;    // expected even-parity bit
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic ebit(input logic [7:0] bits, input logic par, input int j);
        return (j < 8) ? bits[7-j] : par;
    endfunction

    // Called just after a rising edge; waits (bounded) for in_ready.
    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_wait", in_ready, 1'b1);
    endtask

    // Offer one word for exactly one edge.
    task automatic send(input logic [7:0] w);
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Checks the NB output cycles of one word on the GAP=0 instance.
    task automatic check_word(input logic [7:0] bits, input logic par, input bit noise);
        for (int j = 0; j < NB; j++) begin
            @(negedge clk);
            chk("dout",       dout,       ebit(bits, par, j));
            chk("dout_valid", dout_valid, 1'b1);
            chk("dout_last",  dout_last,  (j == NB - 1));
            chk("in_ready",   in_ready,   (j == NB - 1));
            if (noise) begin
                in_valid = (j < NB - 2) ? ~in_valid : 1'b0;
                in_data  = 8'h5A ^ 8'(j);
            end
        end
        $display("word %h serialized (%0d bits)", bits, NB);
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("idle_dout",  dout,       1'b0);
        chk("idle_valid", dout_valid, 1'b0);
        chk("idle_last",  dout_last,  1'b0);
        chk("idle_ready", in_ready,   1'b1);
    endtask

    initial begin
        vecs[0] = '{8'h99, 8'b1001_1001, 1'b0};
        vecs[1] = '{8'hA5, 8'b1010_0101, 1'b0};
        vecs[2] = '{8'h3C, 8'b0011_1100, 1'b0};
        vecs[3] = '{8'h07, 8'b0000_0111, 1'b1};
        vecs[4] = '{8'h03, 8'b0000_0011, 1'b0};
        vecs[5] = '{8'h80, 8'b1000_0000, 1'b1};
        vecs[6] = '{8'h01, 8'b0000_0001, 1'b1};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; g_valid = 1'b0; g_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout",    dout,       1'b0);
        chk("rst_valid",   dout_valid, 1'b0);
        chk("rst_last",    dout_last,  1'b0);
        chk("rst_ready",   in_ready,   1'b0);
        chk("rst_g_ready", g_ready,    1'b0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release_ready0", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("release_ready1",   in_ready, 1'b1);
        chk("release_g_ready1", g_ready,  1'b1);

        // Table-driven single words.
        for (int v = 0; v < 7; v++) begin
            wait_ready();
            send(vecs[v].data);
            check_word(vecs[v].bits, vecs[v].par, 1'b0);
            check_idle();
            @(posedge clk);
            #1;
        end

        // Input noise while not ready must not disturb the current word.
        wait_ready();
        send(8'h99);
        check_word(8'b1001_1001, 1'b0, 1'b1);
        check_idle();
        @(posedge clk);
        #1;

        // Back-to-back words with in_valid held high.
        wait_ready();
        in_data  = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_data  = 8'h3C;
        check_word(8'b1010_0101, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_word(8'b0011_1100, 1'b0, 1'b0);
        check_idle();
        @(posedge clk);
        #1;

        // GAP=3 instance: two words offered continuously.
        chk("g_ready_start", g_ready, 1'b1);
        g_data  = 8'hA5;
        g_valid = 1'b1;
        @(posedge clk);
        #1;
        g_data  = 8'h3C;
        for (int i = 0; i < 2 * NB + 4; i++) begin
            @(negedge clk);
            if (i < NB) begin
                chk("g_dout",  g_dout,       ebit(8'hA5, 1'b0, i));
                chk("g_valid", g_dout_valid, 1'b1);
                chk("g_last",  g_dout_last,  (i == NB - 1));
                chk("g_ready", g_ready,      1'b0);
            end else if (i < NB + 3) begin
                chk("gap_dout",  g_dout,       1'b0);
                chk("gap_valid", g_dout_valid, 1'b0);
                chk("gap_ready", g_ready,      1'b0);
            end else if (i == NB + 3) begin
                chk("gidle_valid", g_dout_valid, 1'b0);
                chk("gidle_ready", g_ready,      1'b1);
                @(posedge clk);
                #1;
                g_valid = 1'b0;
            end else begin
                chk("g2_dout",  g_dout,       ebit(8'h3C, 1'b0, i - NB - 4));
                chk("g2_valid", g_dout_valid, 1'b1);
                chk("g2_last",  g_dout_last,  (i == 2 * NB + 3));
                chk("g2_ready", g_ready,      1'b0);
            end
        end
        @(negedge clk);
        chk("gap_after_valid", g_dout_valid, 1'b0);
        chk("gap_after_ready", g_ready,      1'b0);
        $display("gap instance: words a5, 3c with 3-cycle gap");
        repeat (6) @(posedge clk);
        #1;

        // Reset during the 4th bit of 8'hFF, then a clean 8'h81.
        wait_ready();
        send(8'hFF);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("ff_dout",  dout,       1'b1);
            chk("ff_valid", dout_valid, 1'b1);
        end
        reset = 1'b1;
        #1;
        chk("abort_dout",  dout,       1'b0);
        chk("abort_valid", dout_valid, 1'b0);
        chk("abort_ready", in_ready,   1'b0);
        @(posedge clk);
        #1;
        chk("abort_hold_valid", dout_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rerelease_ready0", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rerelease_ready1", in_ready, 1'b1);
        $display("reset aborted word ff after 4 bits");
        send(8'h81);
        check_word(8'b1000_0001, 1'b0, 1'b0);
        check_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
